// File: rtl/bta_reduce_sched.sv
// Time-multiplexed binary-tree adder: loads NOPS operands, then reduces them in place
// with a single SW-bit adder, one add per cycle, and returns the sum on a valid/ready stream.
module bta_reduce_sched #(
  parameter int unsigned NOPS = 8,
  parameter int unsigned W    = 16,
  parameter int unsigned LG   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        in_data,
  input  logic                in_cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W+LG-1:0]     out_sum,
  output logic                busy
);

  localparam int unsigned SW = W + LG;

  typedef enum logic [1:0] {StLoad, StReduce, StDone} state_e;

  state_e          state_q, state_d;
  logic [LG-1:0]   idx_q, idx_d;
  logic [LG-1:0]   pair_q, pair_d;
  logic [LG-1:0]   span_q, span_d;
  logic [SW-1:0]   bank_q [NOPS];
  logic            cin_q;

  logic            in_fire, out_fire, level_end;
  logic [LG-1:0]   src_lo, src_hi;
  logic [SW-1:0]   add_res;

  assign in_ready  = (state_q == StLoad);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StReduce) || (state_q == StDone);
  assign out_sum   = bank_q[0];

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Sources 2p and 2p+1 are never below p, so in-place writes never clobber unread data.
  assign src_lo    = LG'({pair_q, 1'b0});
  assign src_hi    = src_lo | LG'(1);
  assign add_res   = bank_q[src_lo] + bank_q[src_hi] + SW'(cin_q);
  assign level_end = (pair_q == span_q - LG'(1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pair_d  = pair_q;
    span_d  = span_q;
    unique case (state_q)
      StLoad: begin
        if (in_fire) begin
          if (idx_q == LG'(NOPS - 1)) begin
            state_d = StReduce;
            idx_d   = '0;
            pair_d  = '0;
            span_d  = LG'(NOPS / 2);
          end else begin
            idx_d = idx_q + LG'(1);
          end
        end
      end
      StReduce: begin
        if (level_end) begin
          pair_d = '0;
          span_d = span_q >> 1;
          if (span_q == LG'(1)) state_d = StDone;
        end else begin
          pair_d = pair_q + LG'(1);
        end
      end
      StDone: begin
        if (out_fire) begin
          state_d = StLoad;
          idx_d   = '0;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StLoad;
      idx_q   <= '0;
      pair_q  <= '0;
      span_q  <= '0;
      cin_q   <= 1'b0;
      for (int i = 0; i < NOPS; i++) bank_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pair_q  <= pair_d;
      span_q  <= span_d;
      if (in_fire) begin
        bank_q[idx_q] <= {{LG{1'b0}}, in_data};
        if (idx_q == '0) cin_q <= in_cin;
      end
      if (state_q == StReduce) bank_q[pair_q] <= add_res;
    end
  end

endmodule

// File: tb/tb_bta_reduce_sched.sv
// Directed and randomized checks of bta_reduce_sched against a plain-arithmetic sum model.
module tb_bta_reduce_sched;

  localparam int NOPS = 8;
  localparam int W    = 16;
  localparam int LG   = 3;
  localparam int SW   = W + LG;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_cin;
  logic [W-1:0]  in_data;
  logic          out_valid, out_ready, busy;
  logic [SW-1:0] out_sum;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] ops [NOPS];
  logic         cin_first;
  int           max_gap;

  bta_reduce_sched #(.NOPS(NOPS), .W(W), .LG(LG)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sum of operands plus the carry counted once per internal tree node.
  function automatic longint model_sum();
    longint s = 0;
    for (int i = 0; i < NOPS; i++) s += longint'(ops[i]);
    s += longint'(NOPS - 1) * longint'(cin_first);
    return s;
  endfunction

  task automatic set_ramp(input int step);
    for (int i = 0; i < NOPS; i++) ops[i] = W'((i + 1) * step);
  endtask

  task automatic send_set();
    for (int i = 0; i < NOPS; i++) begin
      int gaps = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gaps) begin
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_cin   = 1'($urandom);
        tick();
      end
      in_valid = 1'b1;
      in_data  = ops[i];
      in_cin   = (i == 0) ? cin_first : ~cin_first;
      check("in_ready_load", in_ready, 1);
      tick();
      in_valid = 1'b0;
      in_data  = W'($urandom);
    end
    check("busy_after_load", busy, 1);
  endtask

  task automatic wait_result(input string tag, input longint exp, input int hold);
    int n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check("latency", n + 1, NOPS);
    for (int k = 0; k < hold; k++) begin
      check("hold_valid", out_valid, 1);
      check("hold_sum", out_sum, exp);
      check("hold_in_ready", in_ready, 0);
      in_valid = 1'b1;
      in_data  = W'($urandom);
      tick();
      in_valid = 1'b0;
    end
    check(tag, out_sum, exp);
    check("done_valid", out_valid, 1);
    check("done_busy", busy, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_in_ready", in_ready, 1);
    check("post_out_valid", out_valid, 0);
    check("post_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_cin = 1'b0; out_ready = 1'b0;
    max_gap = 0; cin_first = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_sum", out_sum, 0);

    // T1: ramp 1..8, no carry
    set_ramp(1); cin_first = 1'b0;
    send_set();
    wait_result("t1_sum", 36, 0);

    // T2: all-ones operands with carry, no wrap
    for (int i = 0; i < NOPS; i++) ops[i] = 16'hFFFF;
    cin_first = 1'b1;
    send_set();
    wait_result("t2_sum", 64'h7FFFF, 0);

    // T3: result back-pressured for 5 cycles with stray input pulses
    set_ramp(1); cin_first = 1'b0;
    send_set();
    wait_result("t3_sum", 36, 5);

    // T4: reset in the third reduce cycle, then a fresh set
    send_set();
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_out_valid", out_valid, 0);
    check("t4_in_ready", in_ready, 1);
    check("t4_busy", busy, 0);
    check("t4_out_sum", out_sum, 0);
    set_ramp(10);
    send_set();
    wait_result("t4_sum", 360, 0);

    // T5: random idle gaps, carry only on the first beat
    set_ramp(1); cin_first = 1'b1; max_gap = 3;
    send_set();
    wait_result("t5_sum", 43, 0);
    max_gap = 0;

    // T6: two sets back-to-back
    set_ramp(1); cin_first = 1'b0;
    send_set();
    wait_result("t6_sum_a", 36, 0);
    set_ramp(10);
    send_set();
    wait_result("t6_sum_b", 360, 0);

    // Randomized sets against the model
    for (int s = 0; s < 10; s++) begin
      for (int i = 0; i < NOPS; i++) ops[i] = W'($urandom);
      cin_first = 1'($urandom);
      max_gap   = int'($urandom_range(2, 0));
      send_set();
      wait_result("rand_sum", model_sum(), int'($urandom_range(2, 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
